// File: rtl/carrier_pkg.sv
// Shared types for the carrier keyer bank: keying modes, keyer states and
// the channel-index width helper.
package carrier_pkg;

  typedef enum logic [1:0] {
    MODE_CW  = 2'd0,
    MODE_OOK = 2'd1,
    MODE_FSK = 2'd2,
    MODE_OFF = 2'd3
  } carrier_mode_t;

  // Keyer states kept as plain constants so older tooling and netlists match.
  typedef logic [0:0] keyer_state_t;
  localparam keyer_state_t ST_IDLE  = 1'b0;
  localparam keyer_state_t ST_SHIFT = 1'b1;

  function automatic int ch_width(input int channels);
    return (channels < 2) ? 1 : $clog2(channels);
  endfunction

endpackage

// File: rtl/carrier_keyer_bank_if.sv
// Byte-stream handshake into the keyer: valid/ready with an 8-bit payload.
interface carrier_keyer_bank_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/nco_channel.sv
// One phase-accumulator NCO: programmable tuning word, free-running
// accumulator, square output taken from the accumulator MSB.
module nco_channel
  import carrier_pkg::*;
#(
  parameter int               ACC_W       = 32,
  parameter logic [ACC_W-1:0] DEFAULT_FTW = '0
) (
  input  logic             CLK,
  input  logic             reset_trigger,
  input  logic             we_i,
  input  logic [ACC_W-1:0] ftw_i,
  output logic             square_o
);

  logic [ACC_W-1:0] ftw_q, ftw_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  // The accumulate sees the tuning word as it was before this edge's write.
  assign acc_d = acc_q + ftw_q;
  assign ftw_d = we_i ? ftw_i : ftw_q;

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge CLK or posedge reset_trigger) begin
    if (reset_trigger) begin
      ftw_q <= DEFAULT_FTW;
      acc_q <= '0;
    end else begin
      ftw_q <= ftw_d;
      acc_q <= acc_d;
    end
  end

  assign square_o = acc_q[ACC_W-1];

endmodule

// File: rtl/carrier_keyer_bank.sv
// Bank of NCO carriers plus a byte-stream keyer (CW / OOK / FSK) driving a
// single registered antenna output.
module carrier_keyer_bank
  import carrier_pkg::*;
#(
  parameter int               CHANNELS    = 8,
  parameter int               ACC_W       = 32,
  parameter int               DIV_W       = 24,
  parameter logic [ACC_W-1:0] DEFAULT_FTW = '0,
  localparam int              CH_W        = ch_width(CHANNELS)
) (
  input  logic                 CLK,
  input  logic                 reset_trigger,
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [ACC_W-1:0]     cfg_ftw,
  input  logic [1:0]           mode,
  input  logic [CH_W-1:0]      mark_ch,
  input  logic [CH_W-1:0]      space_ch,
  input  logic [DIV_W-1:0]     bit_div,
  carrier_keyer_bank_if.slave  s,
  output logic                 carrier_out,
  output logic                 busy,
  output logic                 mark
);

  logic [CHANNELS-1:0] square;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    nco_channel #(
      .ACC_W       (ACC_W),
      .DEFAULT_FTW (DEFAULT_FTW)
    ) u_nco (
      .CLK           (CLK),
      .reset_trigger (reset_trigger),
      .we_i          (cfg_we && (cfg_ch == CH_W'(c))),
      .ftw_i         (cfg_ftw),
      .square_o      (square[c])
    );
  end

  keyer_state_t     state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  carrier_mode_t    mode_q, mode_d;
  logic [CH_W-1:0]  mark_ch_q, mark_ch_d;
  logic [CH_W-1:0]  space_ch_q, space_ch_d;
  logic             rdy_en_q;
  logic             carrier_q, carrier_d;

  carrier_mode_t    mode_live;
  logic [DIV_W-1:0] div_live;
  logic             bit_last, byte_last, fire;
  logic             mark_sq, space_sq, live_sq;

  assign mode_live = carrier_mode_t'(mode);
  assign div_live  = (bit_div == '0) ? DIV_W'(1) : bit_div;

  assign bit_last  = (cnt_q == div_q - DIV_W'(1));
  assign byte_last = (state_q == ST_SHIFT) && bit_last && (bit_idx_q == 3'd7);
  // rdy_en_q holds ready low until the first edge after reset is released.
  assign s.s_ready = rdy_en_q && ((state_q == ST_IDLE) || byte_last);
  assign fire      = s.s_valid && s.s_ready;

  // Channel indices at or above CHANNELS match no channel and read as 0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    mark_sq  = 1'b0;
    space_sq = 1'b0;
    live_sq  = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (mark_ch_q  == CH_W'(c)) mark_sq  = square[c];
      if (space_ch_q == CH_W'(c)) space_sq = square[c];
      if (mark_ch    == CH_W'(c)) live_sq  = square[c];
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    mode_d     = mode_q;
    mark_ch_d  = mark_ch_q;
    space_ch_d = space_ch_q;
    if (fire) begin
      state_d    = ST_SHIFT;
      shreg_d    = s.s_data;
      bit_idx_d  = 3'd0;
      cnt_d      = '0;
      div_d      = div_live;
      mode_d     = mode_live;
      mark_ch_d  = mark_ch;
      space_ch_d = space_ch;
    end else if (state_q == ST_SHIFT) begin
      if (bit_last) begin
        cnt_d = '0;
        if (bit_idx_q == 3'd7) begin
          state_d = ST_IDLE;
        end else begin
          shreg_d   = shreg_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  // In SHIFT the latched config decides; in IDLE only live CW reaches the pin.
  always_comb begin
    carrier_d = 1'b0;
    if (state_q == ST_SHIFT) begin
      unique case (mode_q)
        MODE_CW:  carrier_d = mark_sq;
        MODE_OOK: carrier_d = shreg_q[0] & mark_sq;
        MODE_FSK: carrier_d = shreg_q[0] ? mark_sq : space_sq;
        default:  carrier_d = 1'b0;
      endcase
    end else begin
      carrier_d = (mode_live == MODE_CW) & live_sq;
    end
  end

  always_ff @(posedge CLK or posedge reset_trigger) begin
    if (reset_trigger) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      cnt_q      <= '0;
      div_q      <= DIV_W'(1);
      mode_q     <= MODE_OFF;
      mark_ch_q  <= '0;
      space_ch_q <= '0;
      rdy_en_q   <= 1'b0;
      carrier_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      mode_q     <= mode_d;
      mark_ch_q  <= mark_ch_d;
      space_ch_q <= space_ch_d;
      rdy_en_q   <= 1'b1;
      carrier_q  <= carrier_d;
    end
  end

  assign carrier_out = carrier_q;
  assign busy        = (state_q == ST_SHIFT);
  assign mark        = (state_q == ST_SHIFT) && shreg_q[0];

endmodule

// File: doc/carrier_keyer_bank.md
# carrier_keyer_bank

Parametrised multi-channel carrier synthesiser and keyer for the transmitter PMOD output. A bank of phase-accumulator NCOs with runtime-programmable tuning words replaces fixed per-frequency dividers. A byte-stream keyer modulates the selected carrier in CW, OOK or two-tone FSK at a programmable bit rate. Its registered single-bit output drives the antenna pin directly.

## Interface
- CHANNELS, 8, number of NCO channels (≥2)
- ACC_W, 32, phase accumulator / tuning word width
- DIV_W, 24, width of bit-period divider
- DEFAULT_FTW, 0, tuning word loaded into every channel at reset
- CLK  in  1  master clock
- reset_trigger  in  1  reset, asynchronous, active-high
- cfg_we  in  1  write strobe for tuning word
- cfg_ch  in  CH_W=$clog2(CHANNELS)  channel index written
- cfg_ftw  in  ACC_W  tuning word; f = ftw·f_CLK/2^ACC_W
- mode  in  2  0=CW, 1=OOK, 2=FSK, 3=OFF
- mark_ch  in  CH_W  channel used for bit 1 / CW
- space_ch  in  CH_W  channel used for bit 0 in FSK
- bit_div  in  DIV_W  CLK cycles per bit; 0 treated as 1
- s_valid  in  1  byte available
- s_ready  out  1  keyer accepts byte this cycle
- s_data  in  8  byte to send, LSB first
- carrier_out  out  1  registered keyed carrier
- busy  out  1  keyer in SHIFT state
- mark  out  1  bit currently being keyed

## Operation
- Each channel: acc ← acc + ftw every cycle, mod 2^ACC_W; channel square wave = acc[ACC_W-1].
- cfg_we: ftw[cfg_ch] ← cfg_ftw at the edge. The accumulator is not cleared, so phase stays continuous. A cfg_ch ≥ CHANNELS is ignored.
- Keyer FSM has two states, IDLE and SHIFT.
- IDLE: s_ready=1. On s_valid: latch s_data, mode, mark_ch, space_ch and max(bit_div,1); bit_idx=0, cnt=0; go to SHIFT.
- SHIFT: the current bit is shreg[0]. cnt increments each cycle. When cnt=div-1, shift and set bit_idx+1.
  - The last cycle of bit 7 asserts s_ready. If s_valid is high, load the next byte with no gap and stay in SHIFT; otherwise go to IDLE.
- Output selection, in SHIFT with latched config:
  - CW: mark channel.
  - OOK: mark channel if bit=1, else 0.
  - FSK: mark channel if bit=1, else space channel.
  - OFF: 0.
- Output selection, in IDLE with live inputs: CW gives the mark channel; all other modes give 0.
- Config inputs that change during SHIFT do not affect the byte in flight.
- Out-of-range mark_ch/space_ch selects 0.

## Timing
- Reset (async, immediate): all acc=0, all ftw=DEFAULT_FTW, state=IDLE, carrier_out=0, busy=0, mark=0.
- s_ready is 0 while reset_trigger is high and is 1 from the first edge after release.
- A reset mid-byte aborts the byte, and the byte is lost. Output goes to 0 immediately.
- Handshake at edge T → busy=1 and the bit 0 selection are valid after edge T; carrier_out reflects bit 0 after edge T+1. Selection-to-pin latency is 1 cycle.
- A byte occupies exactly 8·div cycles. Back-to-back bytes have no idle cycle between them.
- A tuning word written at edge T is used in the accumulate at edge T+1.
- A write and an accumulate on the same channel in the same cycle: the accumulate uses the old ftw.
- Accumulator wrap-around is silent. No saturation.

## Structure
- Package carrier_pkg holds:
  - mode encodings MODE_CW/OOK/FSK/OFF (2-bit typedef carrier_mode_t);
  - the FSM state typedef;
  - a helper function for CH_W.
- Sub-module nco_channel(ACC_W, DEFAULT_FTW): contains the ftw register, the accumulator, the write enable and the square output. It is instantiated CHANNELS times via generate.
- The keyer FSM and output mux live in the top-level module.

## Test plan
- **Frequency check.** Setup: reset, ACC_W=32, write ch1 ftw=2^30, mode=CW, mark_ch=1. Required: carrier_out has period 4 cycles, 50% duty, first edge 1 cycle after acc MSB.
- **Single OOK byte.** Setup: bit_div=10, send 0xA5 with mode=OOK. Required: busy high for 80 cycles; mark pattern 1,0,1,0,0,1,0,1 in 10-cycle slots; carrier_out=0 during 0-bits; s_ready low until cycle 79.
- **FSK back-to-back.** Setup: ch0 ftw=2^30, ch1 ftw=2^29, mark=1, space=0, s_valid held with 0xFF then 0x00, bit_div=4. Required: 32 cycles of period-8 output, then 32 cycles of period-4 output, with no IDLE cycle between bytes.
- **Mid-byte reset.** Setup: assert reset_trigger during bit 3. Required: carrier_out, busy and mark go to 0 asynchronously; ftw returns to DEFAULT_FTW; s_ready=1 one edge after release.
- **Edge cases.** Setup: bit_div=0, cfg_ch=CHANNELS write, and mode change mid-byte. Required: each bit lasts 1 cycle; no channel ftw changes; the in-flight byte keeps its latched mode and the new mode applies to the next byte.
- **Phase continuity.** Setup: rewrite ch0 ftw mid-run. Required: acc continues from its current value with no reset glitch; the new period is visible from the next accumulate.
